bus_wait_ctlr: RTL

Bus-cycle controller between the v810 core's external bus and the system's memory and I/O devices. Decodes each cycle at BCYSTn into a ROM, RAM, I/O or unmapped region, holds that region's chip select for the whole cycle, and counts per-region wait states to drive READYn. It also drives SZRQn for the 16-bit ROM. It replaces ad-hoc combinational READYn/chip-select glue around the CPU, upstream of data_bus_resizer and the RAM models.

---
 rtl/bus_wait_ctlr.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bus_wait_ctlr.sv
// Bus-cycle controller for the v810 external bus: region decode, per-region chip select and wait-state READYn/SZRQn.
// Optional macro BUS_TIMEOUT_EN: unmapped cycles wait TIMEOUT states and pulse BUSERR with their READYn.
module bus_wait_ctlr #(
   parameter int ROM_WS  = 0,
   parameter int RAM_WS  = 0,
   parameter int IO_WS   = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic        CE,
   input  logic [31:0] A,
   input  logic        BCYSTn,
   input  logic        DAn,
   input  logic        MRQn,
   input  logic        RW,
   input  logic [3:0]  BEn,
   output logic        READYn,
   output logic        SZRQn,
   output logic        ROM_nCE,
   output logic        RAM_nCE,
   output logic        IO_nCE,
   output logic        BUSERR
);

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } state_t;

   typedef enum logic [7:0] {
      RGN_NONE     = 8'h00,
      RGN_ROM      = 8'h01,
      RGN_RAM      = 8'h02,
      RGN_IO       = 8'h04,
      RGN_UNMAPPED = 8'h08
   } region_t;

   localparam logic [15:0] ROM_WS_W  = 16'(ROM_WS);
   localparam logic [15:0] RAM_WS_W  = 16'(RAM_WS);
   localparam logic [15:0] IO_WS_W   = 16'(IO_WS);
   localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

   state_t      state_q, state_d;
   region_t     region_q, region_d;
   logic [15:0] wcnt_q, wcnt_d;

   region_t     decRegion;
   logic [15:0] decWs;
   logic        readyCycle;

   // DAn/RW/BEn and the low address bits go straight to the devices.
   logic        unusedInputs;
`ifdef BUS_TIMEOUT_EN
   assign unusedInputs = ^{DAn, RW, BEn, A[19:0]};
`else
   assign unusedInputs = ^{DAn, RW, BEn, A[19:0], TIMEOUT_W};
`endif

   always_comb begin
      decRegion = RGN_UNMAPPED;
      if (MRQn) begin
         decRegion = RGN_IO;
      end else if (!A[31]) begin
         decRegion = RGN_RAM;
      end else if (A[31:20] == 12'hFFF) begin
         decRegion = RGN_ROM;
      end
   end

   always_comb begin
      decWs = 16'd0;
      case (decRegion)
         RGN_ROM:      decWs = ROM_WS_W;
         RGN_RAM:      decWs = RAM_WS_W;
         RGN_IO:       decWs = IO_WS_W;
`ifdef BUS_TIMEOUT_EN
         RGN_UNMAPPED: decWs = TIMEOUT_W;
`else
         RGN_UNMAPPED: decWs = 16'd0;
`endif
         default:      decWs = 16'd0;
      endcase
   end

   // A request seen while still counting waits is ignored; only the ready cycle may chain a new one.
   always_comb begin
      state_d  = state_q;
      region_d = region_q;
      wcnt_d   = wcnt_q;
      if (CE) begin
         case (state_q)
            ST_IDLE: begin
               if (!BCYSTn) begin
                  state_d  = ST_ACTIVE;
                  region_d = decRegion;
                  wcnt_d   = decWs;
               end
            end
            ST_ACTIVE: begin
               if (wcnt_q != 16'd0) begin
                  wcnt_d = wcnt_q - 16'd1;
               end else if (!BCYSTn) begin
                  region_d = decRegion;
                  wcnt_d   = decWs;
               end else begin
                  state_d  = ST_IDLE;
                  region_d = RGN_NONE;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               region_d = RGN_NONE;
               wcnt_d   = 16'd0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RES) begin
         state_q  <= ST_IDLE;
         region_q <= RGN_NONE;
         wcnt_q   <= 16'd0;
      end else begin
         state_q  <= state_d;
         region_q <= region_d;
         wcnt_q   <= wcnt_d;
      end
   end

   // Every output comes from registered state, so A/BCYSTn never reach them combinationally.
   always_comb begin
      readyCycle = (state_q == ST_ACTIVE) && (wcnt_q == 16'd0);
      READYn     = !readyCycle;
      SZRQn      = !(readyCycle && (region_q == RGN_ROM));
      ROM_nCE    = !((state_q == ST_ACTIVE) && (region_q == RGN_ROM));
      RAM_nCE    = !((state_q == ST_ACTIVE) && (region_q == RGN_RAM));
      IO_nCE     = !((state_q == ST_ACTIVE) && (region_q == RGN_IO));
`ifdef BUS_TIMEOUT_EN
      BUSERR     = readyCycle && (region_q == RGN_UNMAPPED);
`else
      BUSERR     = 1'b0;
`endif
   end

endmodule
